wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sets the write-back data width.
REQ-002 Parameter ADDR_W, default 4, sets the register-file address width.
REQ-003 Parameter MAX_WAIT, default 3, sets the number of consecutive lost ALU cycles before the ALU is promoted.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 wb_en  input  1  downstream enable; 0 = write port stalled.
REQ-007 alu_valid  input  1  ALU result pending.
REQ-008 alu_rd  input  ADDR_W  ALU destination register.
REQ-009 alu_data  input  DATA_W  ALU result.
REQ-010 alu_ready  output  1  ALU grant in this cycle (combinational).
REQ-011 mem_valid  input  1  load result pending.
REQ-012 mem_rd  input  ADDR_W  load destination register.
REQ-013 mem_data  input  DATA_W  load data.
REQ-014 mem_ready  output  1  load grant in this cycle (combinational).
REQ-015 rf_we  output  1  register-file write enable (registered).
REQ-016 rf_waddr  output  ADDR_W  register-file write address (registered).
REQ-017 rf_wdata  output  DATA_W  register-file write data (registered).
REQ-018 conflict_cnt  output  8  saturating count of cycles in which both sources are valid.

Function
REQ-019 Per cycle, the block SHALL grant at most one source; a transfer occurs when valid and ready are both 1.
REQ-020 When wb_en=0, alu_ready and mem_ready SHALL both be 0.
REQ-021 The FSM SHALL have two states: MEM_PRI (reset state) and ALU_PRI.
REQ-022 In MEM_PRI, mem_ready SHALL equal wb_en&mem_valid, and alu_ready SHALL equal wb_en&alu_valid&!mem_valid.
REQ-023 In ALU_PRI, alu_ready SHALL equal wb_en&alu_valid, and mem_ready SHALL equal wb_en&mem_valid&!alu_valid.
REQ-024 The 2-bit-minimum wait counter SHALL increment on each cycle where alu_valid=1, alu_ready=0, and wb_en=1, and SHALL clear on any ALU transfer.
REQ-025 The FSM SHALL move MEM_PRI->ALU_PRI on the edge at which the wait counter reaches MAX_WAIT.
REQ-026 The FSM SHALL move ALU_PRI->MEM_PRI on the edge following an ALU transfer.
REQ-027 The FSM SHALL also move ALU_PRI->MEM_PRI, with the counter cleared, on any edge where alu_valid=0.
REQ-028 On the edge following a transfer, rf_we, rf_waddr, and rf_wdata SHALL carry the granted source's rd and data (latency 1).
REQ-029 A granted transfer with rd=0 SHALL be acknowledged but SHALL produce rf_we=0 (register 0 is hardwired zero).
REQ-030 In cycles with no transfer, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL hold their last values.
REQ-031 conflict_cnt SHALL increment on each cycle where alu_valid=1 and mem_valid=1, regardless of wb_en, and SHALL saturate at 255.
REQ-032 If a source drops valid without a grant, the block SHALL NOT write its data.

Reset
REQ-033 While reset=0 at a rising edge, the block SHALL set FSM=MEM_PRI, the wait counter to 0, rf_we=0, rf_waddr=0, rf_wdata=0, and conflict_cnt=0.
REQ-034 While reset=0, alu_ready and mem_ready SHALL be 0.
REQ-035 A reset asserted mid-transfer SHALL suppress that transfer's rf_we on the following edge.

Verification
REQ-036 Single ALU write: alu_valid=1, rd=5, data=16'h1234, mem idle, wb_en=1 -> alu_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=16'h1234.
REQ-037 Collision: both sources valid for 1 cycle (mem rd=3, data=16'hBEEF) -> mem granted; next cycle write to r3 with 16'hBEEF; conflict_cnt=1.
REQ-038 Starvation: both sources valid continuously, MAX_WAIT=3 -> mem granted in cycles 0-2, ALU granted in cycle 3, mem granted in cycle 4.
REQ-039 r0 discard: mem_valid=1, rd=0, data=16'hFFFF -> mem_ready=1; next cycle rf_we=0.
REQ-040 Stall: wb_en=0 for 4 cycles with both sources valid -> no grants, rf_we=0, wait counter unchanged, conflict_cnt=4.
REQ-041 Reset: assert reset=0 during an ALU grant -> next cycle rf_we=0, conflict_cnt=0, FSM=MEM_PRI.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-back arbiter: merges ALU and load results onto one write port.
// Loads win by default; an ALU result that keeps losing is promoted after MAX_WAIT cycles.
module wb_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        conflict_cnt
);

  localparam int WAIT_W = ($clog2(MAX_WAIT + 1) < 2) ? 2 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {MEM_PRI, ALU_PRI} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              alu_xfer;
  logic              mem_xfer;

  // Grants are suppressed while reset is held so no transfer can start then.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (reset && wb_en) begin
      if (state == ALU_PRI) begin
        alu_ready = alu_valid;
        mem_ready = mem_valid & ~alu_valid;
      end else begin
        mem_ready = mem_valid;
        alu_ready = alu_valid & ~mem_valid;
      end
    end
  end

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;

  // Only consecutive lost cycles count; a stalled port (wb_en=0) neither counts nor clears.
  always_comb begin
    wait_next = wait_cnt;
    if (alu_xfer || !alu_valid)
      wait_next = '0;
    else if (wb_en && wait_cnt != WAIT_MAX)
      wait_next = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= MEM_PRI;
      wait_cnt     <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      wait_cnt <= wait_next;
      case (state)
        MEM_PRI: if (wait_next == WAIT_MAX) state <= ALU_PRI;
        ALU_PRI: if (alu_xfer || !alu_valid) state <= MEM_PRI;
        default: state <= MEM_PRI;
      endcase

      // r0 is hardwired zero: the transfer is acknowledged but never written.
      rf_we <= 1'b0;
      if (alu_xfer) begin
        rf_we    <= (alu_rd != '0);
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (mem_xfer) begin
        rf_we    <= (mem_rd != '0);
        rf_waddr <= mem_rd;
        rf_wdata <= mem_data;
      end

      if (alu_valid && mem_valid && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a cycle-level priority model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic av, input logic [3:0] ard, input logic [15:0] ad,
                        input logic mv, input logic [3:0] mrd, input logic [15:0] md);
    wb_en = en; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  // Reference model: loads have priority unless the ALU has lost MAX_WAIT consecutive
  // enabled cycles; the promoted ALU keeps priority until it transfers or goes idle.
  initial begin
    bit   m_alu_pri;
    int   m_lost;
    bit   m_we;
    int   m_waddr, m_wdata, m_conf;
    bit   e_alu, e_mem;
    m_alu_pri = 0; m_lost = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_conf = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_alu = 0; e_mem = 0;
      if (reset && wb_en) begin
        if (m_alu_pri) begin
          e_alu = alu_valid; e_mem = mem_valid && !alu_valid;
        end else begin
          e_mem = mem_valid; e_alu = alu_valid && !mem_valid;
        end
      end
      chk("model_alu_ready", alu_ready, e_alu);
      chk("model_mem_ready", mem_ready, e_mem);
      chk("model_rf_we", rf_we, m_we);
      chk("model_rf_waddr", rf_waddr, m_waddr);
      chk("model_rf_wdata", rf_wdata, m_wdata);
      chk("model_conflict_cnt", conflict_cnt, m_conf);
      if (!reset) begin
        m_alu_pri = 0; m_lost = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_conf = 0;
      end else begin
        m_we = 0;
        if (e_alu) begin
          m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
        end else if (e_mem) begin
          m_we = (mem_rd != 0); m_waddr = mem_rd; m_wdata = mem_data;
        end
        if (alu_valid && mem_valid && m_conf < 255) m_conf++;
        if (e_alu || !alu_valid) begin
          m_lost = 0; m_alu_pri = 0;
        end else if (wb_en) begin
          m_lost++;
          if (m_lost >= MAX_WAIT) m_alu_pri = 1;
        end
      end
    end
  end

  initial begin
    logic [4:0] exp_alu;
    exp_alu = 5'b01000;
    reset = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("reset_rf_we", rf_we, 0);
    chk("reset_conflict", conflict_cnt, 0);
    reset = 1'b1;

    // Single ALU write
    set_in(1, 1, 4'd5, 16'h1234, 0, 0, 0);
    #1;
    chk("single_alu_ready", alu_ready, 1);
    chk("single_mem_ready", mem_ready, 0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("single_rf_we", rf_we, 1);
    chk("single_rf_waddr", rf_waddr, 5);
    chk("single_rf_wdata", rf_wdata, 16'h1234);
    cyc();
    chk("idle_rf_we", rf_we, 0);
    chk("idle_hold_waddr", rf_waddr, 5);
    chk("idle_hold_wdata", rf_wdata, 16'h1234);

    // Collision: load wins
    do_reset();
    set_in(1, 1, 4'd7, 16'h1111, 1, 4'd3, 16'hBEEF);
    #1;
    chk("coll_mem_ready", mem_ready, 1);
    chk("coll_alu_ready", alu_ready, 0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("coll_rf_we", rf_we, 1);
    chk("coll_rf_waddr", rf_waddr, 3);
    chk("coll_rf_wdata", rf_wdata, 16'hBEEF);
    chk("coll_conflict", conflict_cnt, 1);

    // r0 discard
    cyc();
    set_in(1, 0, 0, 0, 1, 4'd0, 16'hFFFF);
    #1;
    chk("r0_mem_ready", mem_ready, 1);
    cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("r0_rf_we", rf_we, 0);

    // Starvation: mem, mem, mem, alu, mem
    do_reset();
    set_in(1, 1, 4'd2, 16'h2222, 1, 4'd4, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("starve_alu_ready", alu_ready, exp_alu[i]);
      chk("starve_mem_ready", mem_ready, !exp_alu[i]);
      cyc();
      if (i == 3) chk("starve_alu_waddr", rf_waddr, 2);
    end
    set_in(1, 0, 0, 0, 0, 0, 0);

    // Stall: no grants, wait counter untouched, conflicts still counted
    do_reset();
    set_in(0, 1, 4'd6, 16'h6666, 1, 4'd8, 16'h8888);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_alu_ready", alu_ready, 0);
      chk("stall_mem_ready", mem_ready, 0);
      cyc();
      chk("stall_rf_we", rf_we, 0);
    end
    chk("stall_conflict", conflict_cnt, 4);
    wb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("unstall_alu_ready", alu_ready, exp_alu[i]);
      cyc();
    end

    // Reset during an ALU grant after promotion
    do_reset();
    set_in(1, 1, 4'd9, 16'hABCD, 1, 4'd1, 16'h0101);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_pre_mem_ready", mem_ready, 1);
      cyc();
    end
    chk("rst_pre_conflict", conflict_cnt, 3);
    #1;
    chk("rst_alu_granted", alu_ready, 1);
    reset = 1'b0;
    #1;
    chk("rst_alu_ready_low", alu_ready, 0);
    cyc();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_conflict", conflict_cnt, 0);
    reset = 1'b1;
    #1;
    chk("rst_mem_pri_mem", mem_ready, 1);
    chk("rst_mem_pri_alu", alu_ready, 0);
    cyc();

    // Conflict counter saturation
    set_in(0, 1, 4'd3, 16'h3333, 1, 4'd5, 16'h5555);
    repeat (260) cyc();
    chk("conflict_saturate", conflict_cnt, 255);
    do_reset();

    // Mixed pattern sweep, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      logic [7:0] v;
      v = 8'(i * 37 + 11);
      set_in(v[5:3] != 3'd0, v[0] | v[2], v[3:0] ^ 4'h5, {v, ~v},
             v[1] | v[6], v[4:1], {~v, v});
      cyc();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
